// File: rtl/sdram_tmg_ref_gen_if.sv
// Control/status bundle between an SDRAM command sequencer and its timing/refresh generator.
// The master drives the phase, read and refresh-ack strobes; the slave returns the timing status.
interface sdram_tmg_ref_gen_if;
  logic       phase_start;
  logic [2:0] phase_sel;
  logic [7:0] phase_len;
  logic       rd_start;
  logic       ref_ack;
  logic       done_pwrup;
  logic       phase_busy;
  logic       phase_done;
  logic       rd_valid;
  logic       ref_req;
  logic       ref_urgent;
  logic [3:0] ref_pend;
  logic       ref_ovf;

  modport master (
    output phase_start, phase_sel, phase_len, rd_start, ref_ack,
    input  done_pwrup, phase_busy, phase_done, rd_valid, ref_req, ref_urgent, ref_pend, ref_ovf
  );

  modport slave (
    input  phase_start, phase_sel, phase_len, rd_start, ref_ack,
    output done_pwrup, phase_busy, phase_done, rd_valid, ref_req, ref_urgent, ref_pend, ref_ovf
  );
endinterface

// File: rtl/sdram_tmg_ref_gen.sv
// SDRAM timing helper: power-up wait, refresh scheduling, phase timer and read-valid pipeline.
// All outputs are decodes of registers (one-cycle reaction to strobes); no backpressure, strobes are never stalled.
module sdram_tmg_ref_gen #(
  parameter int PWRUP_CYC    = 26667,
  parameter int REF_PERIOD   = 1040,
  parameter int REF_MAX_PEND = 8,
  parameter int REF_URG_TH   = 6,
  parameter int TRP          = 3,
  parameter int TRFC         = 9,
  parameter int TMRD         = 2,
  parameter int TRCD         = 3,
  parameter int TWR          = 2,
  parameter int TDAL         = 5,
  parameter int CL           = 3,
  parameter int BL           = 4
) (
  input logic                clk,
  input logic                rst_n,
  sdram_tmg_ref_gen_if.slave bus
);

  localparam int PW_W = $clog2(PWRUP_CYC + 1);
  localparam int RP_W = $clog2(REF_PERIOD + 1);

  logic [PW_W-1:0] pwr_cnt_q, pwr_cnt_d;
  logic [RP_W-1:0] ref_cnt_q, ref_cnt_d;
  logic [3:0]      ref_pend_q, ref_pend_d;
  logic            ref_ovf_q, ref_ovf_d;
  logic [7:0]      ph_cnt_q, ph_cnt_d;
  logic [CL-1:0]   dl_q, dl_d;
  logic [3:0]      burst_q, burst_d;

  logic            pwrup_done;
  logic            ref_tick;
  logic [7:0]      ph_len_sel;
  logic [7:0]      ph_len;

  assign pwrup_done = (pwr_cnt_q == PW_W'(PWRUP_CYC));
  assign ref_tick   = pwrup_done && (ref_cnt_q == RP_W'(REF_PERIOD - 1));

  always_comb begin
    pwr_cnt_d = pwrup_done ? pwr_cnt_q : pwr_cnt_q + PW_W'(1);

    ref_cnt_d = '0;
    if (pwrup_done && !ref_tick) ref_cnt_d = ref_cnt_q + RP_W'(1);
  end

  // A tick and an ack in the same cycle cancel out, so neither moves the count.
  always_comb begin
    ref_pend_d = ref_pend_q;
    ref_ovf_d  = ref_ovf_q;
    if (ref_tick && !bus.ref_ack) begin
      if (ref_pend_q == 4'(REF_MAX_PEND)) ref_ovf_d = 1'b1;
      else                                ref_pend_d = ref_pend_q + 4'd1;
    end else if (bus.ref_ack && !ref_tick) begin
      if (ref_pend_q != 4'd0) ref_pend_d = ref_pend_q - 4'd1;
    end
  end

  always_comb begin
    ph_len_sel = '0;
    case (bus.phase_sel)
      3'd0:    ph_len_sel = 8'(TRP);
      3'd1:    ph_len_sel = 8'(TRFC);
      3'd2:    ph_len_sel = 8'(TMRD);
      3'd3:    ph_len_sel = 8'(TRCD);
      3'd4:    ph_len_sel = 8'(TWR);
      3'd5:    ph_len_sel = 8'(TDAL);
      3'd6:    ph_len_sel = 8'(BL);
      default: ph_len_sel = bus.phase_len;
    endcase
    ph_len = (ph_len_sel == 8'd0) ? 8'd1 : ph_len_sel;
  end

  // Remaining cycles of the phase; 1 marks the final (done) cycle, and a restart simply reloads.
  always_comb begin
    ph_cnt_d = '0;
    if (bus.phase_start)        ph_cnt_d = ph_len;
    else if (ph_cnt_q != 8'd0)  ph_cnt_d = ph_cnt_q - 8'd1;
  end

  // CL-deep delay line feeds a burst counter that any newer read reloads.
  always_comb begin
    dl_d    = '0;
    dl_d[0] = bus.rd_start;
    for (int i = 1; i < CL; i++) dl_d[i] = dl_q[i-1];

    burst_d = '0;
    if (dl_q[CL-1])            burst_d = 4'(BL);
    else if (burst_q != 4'd0)  burst_d = burst_q - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwr_cnt_q  <= '0;
      ref_cnt_q  <= '0;
      ref_pend_q <= '0;
      ref_ovf_q  <= 1'b0;
      ph_cnt_q   <= '0;
      dl_q       <= '0;
      burst_q    <= '0;
    end else begin
      pwr_cnt_q  <= pwr_cnt_d;
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
      ref_ovf_q  <= ref_ovf_d;
      ph_cnt_q   <= ph_cnt_d;
      dl_q       <= dl_d;
      burst_q    <= burst_d;
    end
  end

  assign bus.done_pwrup = pwrup_done;
  assign bus.phase_busy = (ph_cnt_q != 8'd0);
  assign bus.phase_done = (ph_cnt_q == 8'd1);
  assign bus.rd_valid   = (burst_q != 4'd0);
  assign bus.ref_pend   = ref_pend_q;
  assign bus.ref_req    = (ref_pend_q != 4'd0);
  assign bus.ref_urgent = (ref_pend_q >= 4'(REF_URG_TH));
  assign bus.ref_ovf    = ref_ovf_q;

endmodule
